// File: rtl/ls_74194_pkg.sv
// Shared mode encoding and default width for the ls_74194 universal shift register.
package ls_74194_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_t;

  localparam int LS_74194_DEF_WIDTH = 4;

endpackage

// File: rtl/ls_74194_bit_cell.sv
// One bit slice of ls_74194: a cleared flop fed by a 4:1 mux of hold, neighbour bits and load data.
module ls_74194_bit_cell
  import ls_74194_pkg::*;
(
  input  logic       clk,
  input  logic       clear_n,
  input  logic [1:0] s,
  input  logic       from_left,
  input  logic       from_right,
  input  logic       p_bit,
  output logic       q
);

  // from_left is the next-higher bit (shift right); from_right is the next-lower bit (shift left).
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      q <= 1'b0;
    end else begin
      case (s)
        MODE_HOLD: q <= q;
        MODE_SHR:  q <= from_left;
        MODE_SHL:  q <= from_right;
        MODE_LOAD: q <= p_bit;
        default:   q <= 1'bx;
      endcase
    end
  end

endmodule

// File: rtl/ls_74194.sv
// WIDTH-bit 74LS194-style universal shift register (hold / shift right / shift left / load).
// Optional macro LS_74194_SERIAL_OUT_EN adds cascade outputs sor = q[0] and sol = q[WIDTH-1].
module ls_74194
  import ls_74194_pkg::*;
#(
  parameter int WIDTH = LS_74194_DEF_WIDTH
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic [1:0]       s,
  input  logic [WIDTH-1:0] p,
  input  logic             sil,
  input  logic             sir,
`ifdef LS_74194_SERIAL_OUT_EN
  output logic             sor,
  output logic             sol,
`endif
  output logic [WIDTH-1:0] q
);

  // End cells take the serial inputs in place of the missing neighbour.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic from_left;
    logic from_right;

    if (i == WIDTH - 1) begin : g_msb
      assign from_left = sir;
    end else begin : g_inner_l
      assign from_left = q[i+1];
    end

    if (i == 0) begin : g_lsb
      assign from_right = sil;
    end else begin : g_inner_r
      assign from_right = q[i-1];
    end

    ls_74194_bit_cell u_cell (
      .clk        (clk),
      .clear_n    (clear_n),
      .s          (s),
      .from_left  (from_left),
      .from_right (from_right),
      .p_bit      (p[i]),
      .q          (q[i])
    );
  end

`ifdef LS_74194_SERIAL_OUT_EN
  assign sor = q[0];
  assign sol = q[WIDTH-1];
`endif

endmodule

// File: tb/tb_ls_74194.sv
// Directed self-checking bench for ls_74194 (WIDTH=4), optionally with LS_74194_SERIAL_OUT_EN.
module tb_ls_74194;

  logic       clk;
  logic       clear_n;
  logic [1:0] s;
  logic [3:0] p;
  logic       sil;
  logic       sir;
  logic [3:0] q;
`ifdef LS_74194_SERIAL_OUT_EN
  logic       sor;
  logic       sol;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  ls_74194 #(.WIDTH(4)) dut (
    .clk     (clk),
    .clear_n (clear_n),
    .s       (s),
    .p       (p),
    .sil     (sil),
    .sir     (sir),
`ifdef LS_74194_SERIAL_OUT_EN
    .sor     (sor),
    .sol     (sol),
`endif
    .q       (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [3:0] actual, input logic [3:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %b, expected %b", tag, actual, expected);
    end
  endtask

  // q plus, when present, the cascade outputs that mirror its end bits
  task automatic checkState(input string tag, input logic [3:0] expected);
    checkOutput(tag, q, expected);
`ifdef LS_74194_SERIAL_OUT_EN
    checkOutput({tag, "_sor"}, {3'b000, sor}, {3'b000, expected[0]});
    checkOutput({tag, "_sol"}, {3'b000, sol}, {3'b000, expected[3]});
`endif
  endtask

  // Drive inputs on the falling edge, then sample 1ns after the next rising edge.
  task automatic applyStimulus(input logic [1:0] mode, input logic [3:0] data,
                               input logic sl, input logic sr);
    @(negedge clk);
    s   = mode;
    p   = data;
    sil = sl;
    sir = sr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_n = 1'b0;
    s   = 2'b00;
    p   = 4'b1010;
    sil = 1'b0;
    sir = 1'b0;
    #1;
    checkState("clear_async", 4'b0000);

    applyStimulus(2'b00, 4'b1010, 1'b0, 1'b0);
    checkState("clear_edge_hold", 4'b0000);
    applyStimulus(2'b11, 4'b1010, 1'b0, 1'b0);
    checkState("clear_edge_load", 4'b0000);

    @(negedge clk);
    clear_n = 1'b1;

    applyStimulus(2'b11, 4'b1010, 1'b0, 1'b0);
    checkState("load", 4'b1010);
    applyStimulus(2'b01, 4'b1111, 1'b1, 1'b0);
    checkState("shr_sir0", 4'b0101);
    applyStimulus(2'b01, 4'b0000, 1'b0, 1'b1);
    checkState("shr_sir1", 4'b1010);
    applyStimulus(2'b01, 4'b0000, 1'b0, 1'b0);
    checkState("shr_again", 4'b0101);
    applyStimulus(2'b10, 4'b0000, 1'b1, 1'b0);
    checkState("shl_sil1", 4'b1011);
    applyStimulus(2'b10, 4'b1111, 1'b0, 1'b1);
    checkState("shl_sil0", 4'b0110);

    applyStimulus(2'b11, 4'b1010, 1'b0, 1'b0);
    checkState("reload", 4'b1010);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(2'b00, 4'b0101, 1'b1, 1'b1);
      checkState($sformatf("hold%0d", i), 4'b1010);
    end

    applyStimulus(2'b11, 4'b1001, 1'b0, 1'b0);
    checkState("load_1001", 4'b1001);
    applyStimulus(2'b10, 4'b0000, 1'b0, 1'b1);
    checkState("shl_msb_out", 4'b0010);
    applyStimulus(2'b11, 4'b1001, 1'b0, 1'b0);
    checkState("load_1001b", 4'b1001);
    applyStimulus(2'b01, 4'b0000, 1'b1, 1'b0);
    checkState("shr_lsb_out", 4'b0100);

    // Mid-shift clear pulse of 3ns that lands entirely between two rising edges.
    applyStimulus(2'b01, 4'b0000, 1'b0, 1'b1);
    checkState("shr_before_clr", 4'b1010);
    clear_n = 1'b0;
    #1;
    checkState("clear_mid", 4'b0000);
    #2;
    clear_n = 1'b1;
    #0;
    checkState("clear_released", 4'b0000);
    applyStimulus(2'b01, 4'b0000, 1'b0, 1'b1);
    checkState("shr_after_clr", 4'b1000);
    applyStimulus(2'b01, 4'b0000, 1'b0, 1'b1);
    checkState("shr_after_clr2", 4'b1100);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
